// File: rtl/fir_stream_ctrl.sv
// Sequencer and coefficient bank for a 27-tap FIR: loads taps while idle, steps the FIR
// from a valid/ready sample stream, drains the tail with zeros and presents results as a stream.
module fir_stream_ctrl #(
    parameter int NTAPS     = 27,
    parameter int CW        = 9,
    parameter int DW        = 4,
    parameter int OW        = 16,
    parameter bit SKIP_FILL = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_we,
    input  logic [4:0]            cfg_addr,
    input  logic [CW-1:0]         cfg_data,
    output logic                  cfg_err,
    input  logic                  start,
    input  logic                  flush,
    input  logic                  s_valid,
    input  logic [DW-1:0]         s_data,
    output logic                  s_ready,
    output logic [DW-1:0]         fir_i_mag,
    output logic                  fir_en_n,
    output logic                  fir_clr,
    output logic [NTAPS*CW-1:0]   coef,
    input  logic [OW-1:0]         fir_out,
    output logic                  m_valid,
    output logic [OW-1:0]         m_data,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int                CNTW = $clog2(NTAPS);
    localparam logic [CNTW-1:0]   LAST = CNTW'(NTAPS - 1);
    localparam logic [CNTW-1:0]   ONE  = CNTW'(1);

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DRAIN} state_t;

    state_t                   state, state_nx;
    logic [NTAPS-1:0][CW-1:0] coef_q;
    logic [CNTW-1:0]          fill_cnt, drain_cnt;
    logic                     step, emit, addr_ok, wr_ok;

    assign addr_ok  = 32'(cfg_addr) < NTAPS;
    assign wr_ok    = cfg_we & (state == IDLE) & addr_ok;
    assign fir_en_n = ~step;
    assign fir_clr  = (state == CLEAR);
    assign busy     = (state != IDLE);
    assign m_data   = fir_out;
    assign coef     = coef_q;

    // The output slot is free when empty or being emptied this cycle; every FIR step
    // produces a new result, so a step is only allowed into a free slot.
    always_comb begin
        state_nx  = state;
        step      = 1'b0;
        emit      = 1'b0;
        s_ready   = 1'b0;
        fir_i_mag = '0;
        case (state)
            IDLE:  if (start) state_nx = CLEAR;
            CLEAR: state_nx = RUN;
            RUN: begin
                s_ready   = ~m_valid | m_ready;
                step      = s_valid & s_ready;
                fir_i_mag = s_data;
                emit      = step & (!SKIP_FILL || fill_cnt >= LAST);
                if (flush) state_nx = DRAIN;
            end
            DRAIN: begin
                step = ~m_valid | m_ready;
                emit = step;
                if (step && drain_cnt == ONE) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            coef_q    <= '0;
            fill_cnt  <= '0;
            drain_cnt <= '0;
            m_valid   <= 1'b0;
            cfg_err   <= 1'b0;
            done      <= 1'b0;
        end else begin
            state   <= state_nx;
            cfg_err <= cfg_we & ~wr_ok;
            done    <= (state == DRAIN) & step & (drain_cnt == ONE);
            if (wr_ok) coef_q[cfg_addr] <= cfg_data;

            if (state == CLEAR) begin
                fill_cnt <= '0;
                m_valid  <= 1'b0;
            end else if (emit) begin
                m_valid <= 1'b1;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end

            if (state == RUN && step && fill_cnt < LAST) fill_cnt <= fill_cnt + ONE;

            // Tail is always NTAPS-1 zero steps, however short the run was.
            if (state == RUN && flush)        drain_cnt <= LAST;
            else if (state == DRAIN && step)  drain_cnt <= drain_cnt - ONE;
        end
    end

endmodule

// File: tb/tb_fir_stream_ctrl.sv
// Bench for fir_stream_ctrl: two instances (SKIP_FILL=0 and 1) share stimulus, each
// drives its own behavioural 27-tap FIR; results are compared with hand-computed values.
module tb_fir_stream_ctrl;
    localparam int NT = 27, CW = 9, DW = 4, OW = 16;

    logic clk = 1'b0, rst_n = 1'b0;
    logic cfg_we = 1'b0; logic [4:0] cfg_addr = '0; logic [CW-1:0] cfg_data = '0;
    logic start = 1'b0, flush = 1'b0, s_valid = 1'b0, m_ready = 1'b1, tog = 1'b0;
    logic [DW-1:0] s_data = '0;

    logic cfg_err[2], s_ready[2], fir_en_n[2], fir_clr[2], m_valid[2], busy[2], done[2];
    logic [DW-1:0] fir_i_mag[2];
    logic [NT-1:0][CW-1:0] coef[2];
    logic [OW-1:0] m_data[2];

    int n_chk = 0, n_err = 0;
    int dcnt[2];
    logic pst[2];
    logic [OW-1:0] pd[2];
    logic [OW-1:0] q0[$], q1[$], expq[$];

    always #5 clk = ~clk;

    function automatic logic [OW-1:0] fir_calc(input logic [NT-1:0][CW-1:0] c,
                                               input logic [NT-1:0][DW-1:0] d);
        int acc = 0;
        for (int k = 0; k < NT; k++) acc += int'($signed(c[k])) * int'($signed(d[k]));
        return acc[OW-1:0];
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [NT-1:0][DW-1:0] dl = '0;
        logic [OW-1:0] fo = '0;
        fir_stream_ctrl #(.NTAPS(NT), .CW(CW), .DW(DW), .OW(OW), .SKIP_FILL(g == 1)) u_dut (
            .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
            .cfg_err(cfg_err[g]), .start(start), .flush(flush), .s_valid(s_valid),
            .s_data(s_data), .s_ready(s_ready[g]), .fir_i_mag(fir_i_mag[g]),
            .fir_en_n(fir_en_n[g]), .fir_clr(fir_clr[g]), .coef(coef[g]), .fir_out(fo),
            .m_valid(m_valid[g]), .m_data(m_data[g]), .m_ready(m_ready), .busy(busy[g]),
            .done(done[g]));
        // Registered FIR: newest sample in tap 0, result updates on the enabled edge.
        always @(posedge clk) begin
            if (fir_clr[g]) begin
                dl <= '0;
                fo <= '0;
            end else if (!fir_en_n[g]) begin
                dl <= {dl[NT-2:0], fir_i_mag[g]};
                fo <= fir_calc(coef[g], {dl[NT-2:0], fir_i_mag[g]});
            end
        end
    end

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clock: stall invariants and output collection at the falling edge, then
    // return 1 time unit after the rising edge, where new inputs are applied.
    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (rst_n) begin
                if (m_valid[i] && !m_ready) begin
                    chk($sformatf("stall_s_ready%0d", i), 256'(s_ready[i]), 256'(0));
                    chk($sformatf("stall_fir_en_n%0d", i), 256'(fir_en_n[i]), 256'(1));
                end
                if (pst[i] && m_valid[i])
                    chk($sformatf("stall_hold%0d", i), 256'(m_data[i]), 256'(pd[i]));
                if (m_valid[i] && m_ready) begin
                    if (i == 0) q0.push_back(m_data[0]);
                    else        q1.push_back(m_data[1]);
                end
                if (done[i]) dcnt[i]++;
            end
            pst[i] = rst_n && m_valid[i] && !m_ready;
            pd[i]  = m_data[i];
        end
        @(posedge clk);
        #1;
        if (tog) m_ready = ~m_ready;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        q0.delete(); q1.delete();
        dcnt[0] = 0; dcnt[1] = 0;
    endtask

    task automatic write_coef(input int a, input logic [CW-1:0] d);
        cfg_we = 1'b1; cfg_addr = 5'(a); cfg_data = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input int idx, input logic [DW-1:0] d);
        logic ok = 1'b0;
        s_valid = 1'b1; s_data = d;
        for (int i = 0; i < 50; i++) begin
            ok = s_ready[idx];
            tick();
            if (ok) break;
        end
        if (!ok) chk("send_timeout", 256'(0), 256'(1));
    endtask

    task automatic end_stream();
        s_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic wait_done(input int idx);
        logic seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (done[idx]) begin
                seen = 1'b1;
                chk($sformatf("busy_with_done%0d", idx), 256'(busy[idx]), 256'(0));
                break;
            end
            tick();
        end
        if (!seen) chk("done_timeout", 256'(0), 256'(1));
        repeat (4) tick();
    endtask

    task automatic cmp_q(input string nm, input int idx, input logic [OW-1:0] e[$]);
        logic [OW-1:0] q[$];
        q = (idx == 0) ? q0 : q1;
        chk({nm, "_count"}, 256'(q.size()), 256'(e.size()));
        for (int i = 0; i < e.size() && i < q.size(); i++)
            chk($sformatf("%s[%0d]", nm, i), 256'(q[i]), 256'(e[i]));
    endtask

    typedef struct {
        logic            we;
        logic [4:0]      addr;
        logic [CW-1:0]   data;
        logic            err;
        int              tap;
        logic [CW-1:0]   tap_val;
    } cvec_t;

    task automatic apply_cfg(input cvec_t v);
        cfg_we = v.we; cfg_addr = v.addr; cfg_data = v.data;
        tick();
        cfg_we = 1'b0;
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("cfg_err%0d_a%0d", g, v.addr), 256'(cfg_err[g]), 256'(v.err));
            chk($sformatf("coef%0d_t%0d", g, v.tap), 256'(coef[g][v.tap]), 256'(v.tap_val));
        end
    endtask

    initial begin
        cvec_t tbl[6];
        cvec_t run_wr;
        tbl[0] = '{1'b1, 5'd0,  9'h001, 1'b0, 0,  9'h001};
        tbl[1] = '{1'b1, 5'd26, 9'h0AA, 1'b0, 26, 9'h0AA};
        tbl[2] = '{1'b1, 5'd27, 9'h0FF, 1'b1, 26, 9'h0AA};
        tbl[3] = '{1'b1, 5'd31, 9'h1FF, 1'b1, 0,  9'h001};
        tbl[4] = '{1'b1, 5'd26, 9'h000, 1'b0, 26, 9'h000};
        tbl[5] = '{1'b0, 5'd5,  9'h1FF, 1'b0, 5,  9'h000};
        run_wr = '{1'b1, 5'd3,  9'h0FF, 1'b1, 3,  9'h001};

        // Reset state
        do_reset();
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("rst_busy%0d", g), 256'(busy[g]), 256'(0));
            chk($sformatf("rst_m_valid%0d", g), 256'(m_valid[g]), 256'(0));
            chk($sformatf("rst_fir_en_n%0d", g), 256'(fir_en_n[g]), 256'(1));
            chk($sformatf("rst_fir_clr%0d", g), 256'(fir_clr[g]), 256'(0));
            chk($sformatf("rst_done%0d", g), 256'(done[g]), 256'(0));
            chk($sformatf("rst_cfg_err%0d", g), 256'(cfg_err[g]), 256'(0));
            chk($sformatf("rst_coef%0d", g), 256'(coef[g]), 256'(0));
        end

        // Coefficient writes in IDLE, including out-of-range addresses
        foreach (tbl[i]) apply_cfg(tbl[i]);

        // Identity filter (coef[0]=1): samples pass straight through, then 26 zero drains
        pulse_start();
        for (int v = 1; v <= 5; v++) send(0, 4'(v));
        end_stream();
        wait_done(0);
        expq.delete();
        for (int v = 1; v <= 5; v++) expq.push_back(16'(v));
        repeat (26) expq.push_back(16'h0000);
        cmp_q("t1_out0", 0, expq);
        expq.delete();
        repeat (26) expq.push_back(16'h0000);
        cmp_q("t1_out1", 1, expq);
        chk("t1_done_cnt0", 256'(dcnt[0]), 256'(1));
        chk("t1_done_cnt1", 256'(dcnt[1]), 256'(1));

        // All-ones filter, SKIP_FILL=1: first output only with the 27th sample
        do_reset();
        for (int k = 0; k < NT; k++) write_coef(k, 9'h001);
        pulse_start();
        tick();
        pulse_start();
        chk("start_in_run_clr", 256'(fir_clr[1]), 256'(0));
        apply_cfg(run_wr);
        for (int i = 0; i < 26; i++) send(1, 4'h1);
        chk("t2_no_early_valid", 256'(m_valid[1]), 256'(0));
        chk("t2_no_early_out", 256'(q1.size()), 256'(0));
        send(1, 4'h1);
        chk("t2_first_valid", 256'(m_valid[1]), 256'(1));
        chk("t2_first_data", 256'(m_data[1]), 256'(27));
        end_stream();
        wait_done(1);
        expq.delete();
        for (int v = 27; v >= 1; v--) expq.push_back(16'(v));
        cmp_q("t2_out1", 1, expq);
        chk("t2_done_cnt1", 256'(dcnt[1]), 256'(1));

        // Same run with m_ready toggling: identical output sequence
        do_reset();
        for (int k = 0; k < NT; k++) write_coef(k, 9'h001);
        pulse_start();
        tog = 1'b1;
        for (int i = 0; i < 27; i++) send(1, 4'h1);
        end_stream();
        wait_done(1);
        tog = 1'b0;
        m_ready = 1'b1;
        repeat (3) tick();
        cmp_q("t3_out1", 1, expq);
        chk("t3_done_cnt1", 256'(dcnt[1]), 256'(1));

        // Signed products: coef[1]=-2, samples -8 then 7; write and start share a cycle
        do_reset();
        cfg_we = 1'b1; cfg_addr = 5'd1; cfg_data = 9'h1FE; start = 1'b1;
        tick();
        cfg_we = 1'b0; start = 1'b0;
        chk("t6_coef1", 256'(coef[0][1]), 256'(9'h1FE));
        chk("t6_clear_after_start", 256'(fir_clr[0]), 256'(1));
        send(0, 4'h8);
        send(0, 4'h7);
        end_stream();
        wait_done(0);
        expq.delete();
        expq.push_back(16'h0000); expq.push_back(16'h0010); expq.push_back(16'hFFF2);
        repeat (25) expq.push_back(16'h0000);
        cmp_q("t6_out0", 0, expq);
        expq.delete();
        expq.push_back(16'hFFF2);
        repeat (25) expq.push_back(16'h0000);
        cmp_q("t6_out1", 1, expq);

        // Reset in the middle of a drain aborts with no done pulse
        do_reset();
        write_coef(0, 9'h001);
        pulse_start();
        for (int v = 1; v <= 3; v++) send(0, 4'(v));
        end_stream();
        repeat (4) tick();
        chk("t5_busy_before", 256'(busy[0]), 256'(1));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("t5_busy%0d", g), 256'(busy[g]), 256'(0));
            chk($sformatf("t5_m_valid%0d", g), 256'(m_valid[g]), 256'(0));
            chk($sformatf("t5_fir_en_n%0d", g), 256'(fir_en_n[g]), 256'(1));
            chk($sformatf("t5_coef%0d", g), 256'(coef[g]), 256'(0));
        end
        repeat (30) tick();
        chk("t5_no_done0", 256'(dcnt[0]), 256'(0));
        chk("t5_idle_after0", 256'(busy[0]), 256'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
